// File: rtl/param_regfile.sv
// param_regfile: two-read/one-write register file with a one-entry write pipeline and optional read bypass
module param_regfile #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   RegWrite,
    input  logic [ADDR_W-1:0]      WriteRegister,
    input  logic [DATA_W-1:0]      WriteData,
    input  logic [ADDR_W-1:0]      ReadRegister1,
    input  logic [ADDR_W-1:0]      ReadRegister2,
    output logic [DATA_W-1:0]      ReadData1,
    output logic [DATA_W-1:0]      ReadData2,
    output logic [(1<<ADDR_W)-1:0] selectReg,
    output logic                   wr_pending
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regArray [NREG];
    logic [ADDR_W-1:0] pendAddr;
    logic [DATA_W-1:0] pendData;
    logic              captureOk;

    assign captureOk = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '1));

    // Commit the held write while capturing the next one, so writes stream at one per cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regArray[i] <= '0;
            pendAddr   <= '0;
            pendData   <= '0;
            wr_pending <= 1'b0;
        end else begin
            if (wr_pending) regArray[pendAddr] <= pendData;
            wr_pending <= captureOk;
            if (captureOk) begin
                pendAddr <= WriteRegister;
                pendData <= WriteData;
            end
        end
    end

    // Reads: hardwired zero first, then the held write, then the array
    always_comb begin
        ReadData1 = ((ZERO_REG != 0) && (ReadRegister1 == '1)) ? '0 :
                    ((BYPASS != 0) && wr_pending && (ReadRegister1 == pendAddr)) ? pendData :
                    regArray[ReadRegister1];
        ReadData2 = ((ZERO_REG != 0) && (ReadRegister2 == '1)) ? '0 :
                    ((BYPASS != 0) && wr_pending && (ReadRegister2 == pendAddr)) ? pendData :
                    regArray[ReadRegister2];
        selectReg = wr_pending ? ({{(NREG-1){1'b0}}, 1'b1} << pendAddr) : '0;
    end
endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning register-index width; register count NREG = 2^ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning register data width.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning that when 1, register NREG-1 is hardwired to zero.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning that when 1, reads forward the pending write.

Interface
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port RegWrite, input, 1 bit: write request this cycle.
REQ-008 The block SHALL have port WriteRegister, input, ADDR_W bits: write index.
REQ-009 The block SHALL have port WriteData, input, DATA_W bits: write data.
REQ-010 The block SHALL have port ReadRegister1, input, ADDR_W bits: read index, port 1.
REQ-011 The block SHALL have port ReadRegister2, input, ADDR_W bits: read index, port 2.
REQ-012 The block SHALL have port ReadData1, output, DATA_W bits: read data, port 1, combinational from state and read index.
REQ-013 The block SHALL have port ReadData2, output, DATA_W bits: read data, port 2, same rules as port 1.
REQ-014 The block SHALL have port selectReg, output, NREG bits: one-hot decode of the pending write index, all zero when nothing is pending.
REQ-015 The block SHALL have port wr_pending, output, 1 bit: a write is held in the pending stage.

Function
REQ-016 Writes SHALL use two stages: capture at edge N, commit to the array at edge N+1.
REQ-017 At edge N with RegWrite=1 and a writable index, pend_addr/pend_data SHALL load WriteRegister/WriteData and wr_pending SHALL become 1.
REQ-018 At edge N with RegWrite=0, wr_pending SHALL become 0.
REQ-019 An existing pending entry SHALL commit at the same edge a new entry is captured; back-to-back writes sustain 1 write/cycle with no stall.
REQ-020 Consecutive writes to the same index SHALL resolve with the later write winning, in both array and bypass.
REQ-021 With ZERO_REG=1, a write to index NREG-1 SHALL be dropped: no capture, wr_pending=0 next cycle, and that selectReg bit never asserts.
REQ-022 selectReg SHALL equal (1 << pend_addr) when wr_pending=1, else 0, and SHALL never have more than one bit set.
REQ-023 Read priority per port SHALL be: (a) ZERO_REG=1 and index=NREG-1 -> 0; (b) BYPASS=1, wr_pending=1, index=pend_addr -> pend_data; (c) array[index].
REQ-024 A same-cycle RegWrite SHALL NOT be visible on reads before edge N; visibility is after edge N with BYPASS=1, and after edge N+1 with BYPASS=0.
REQ-025 Both read ports SHALL be independent and may address the same or any index simultaneously.
REQ-026 No arithmetic SHALL be performed; indices are unsigned and all NREG values are legal with no wrap.

Reset
REQ-027 reset_n=0 at an edge SHALL clear all array entries to 0 and clear wr_pending, pend_addr and pend_data to 0.
REQ-028 During reset, selectReg SHALL be 0 and ReadData1/ReadData2 SHALL be 0 from the following cycle.
REQ-029 A write captured or pending when reset_n=0 SHALL be discarded and never committed.
REQ-030 RegWrite sampled in the same edge as reset_n=0 SHALL be ignored.
REQ-031 Operation SHALL resume at the first edge with reset_n=1.

Verification
REQ-032 Reset then read all indices -> every ReadData = 0, selectReg = 0, wr_pending = 0.
REQ-033 Defaults; write idx 5 = 0xDEAD_BEEF at edge N; read idx 5 after edge N -> 0xDEAD_BEEF via bypass, selectReg = 0x0000_0020; after N+1 -> same value from array, selectReg = 0.
REQ-034 BYPASS=0; same write as REQ-033 -> read idx 5 = 0 after edge N, 0xDEAD_BEEF after edge N+1.
REQ-035 Back-to-back writes idx 3=0x11, idx 3=0x22, idx 4=0x33 -> idx 3 reads 0x22 and idx 4 reads 0x33 after completion; selectReg one-hot every cycle.
REQ-036 Write idx 31 = 0xFFFF -> ReadData = 0, selectReg[31] never set, wr_pending = 0.
REQ-037 Write idx 7 = 0xAA, assert reset_n=0 at the next edge -> idx 7 reads 0, wr_pending = 0.
REQ-038 Sweep all indices with RegWrite=0/1 -> selectReg matches the decode with RegWrite=1 and is 0 with RegWrite=0.
